// File: rtl/nios2_oci_pkg.sv
// Shared types and jdo field positions for the OCI memory arbiter and its JTAG command front end.
package nios2_oci_pkg;

  localparam int unsigned OCIMEM_DEPTH = 256;
  localparam int unsigned JDO_W        = 38;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BE_W         = 4;

  localparam int unsigned JDO_ADDR_HI = 17;
  localparam int unsigned JDO_ADDR_LO = 10;
  localparam int unsigned JDO_DATA_HI = 34;
  localparam int unsigned JDO_DATA_LO = 3;
  localparam int unsigned JDO_RDFLAG  = 35;

  typedef enum logic [2:0] {
    StIdle,
    StAvWr,
    StAvRd,
    StAvRdw,
    StJtWr,
    StJtRd,
    StJtRdw
  } oci_state_e;

  typedef enum logic {
    GrantAv,
    GrantJt
  } grant_e;

  // Pending JTAG command; the address is taken from jaddr at grant time.
  typedef struct packed {
    logic              wr;
    logic              incr;
    logic [DATA_W-1:0] wdata;
  } jt_cmd_t;

  function automatic logic is_jt_state(input oci_state_e s);
    return (s == StJtWr) || (s == StJtRd) || (s == StJtRdw);
  endfunction

endpackage

// File: rtl/ethernet_sys_nios2_gen2_0_cpu_ocimem_jtag_cmd.sv
// JTAG strobe decode: jaddr register, one-deep command slot and sticky overrun detection.
module ethernet_sys_nios2_gen2_0_cpu_ocimem_jtag_cmd
  import nios2_oci_pkg::*;
#(
  parameter int unsigned RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  i_jdo,
  input  logic              i_take_action_a,
  input  logic              i_take_action_b,
  input  logic              i_take_no_action_a,
  input  logic              i_busy,
  input  logic              i_grant,
  output logic              o_pend,
  output logic              o_cmd_wr,
  output logic [DATA_W-1:0] o_cmd_wdata,
  output logic [RAM_AW-1:0] o_jaddr,
  output logic              o_queued,
  output logic              o_overrun
);

  logic              w_strobe;
  logic              w_blocked;
  logic              w_accept;
  logic              w_queue;
  logic              w_unused_jdo;
  jt_cmd_t           w_cmd_new;

  logic              r_pend;
  jt_cmd_t           r_cmd;
  logic [RAM_AW-1:0] r_jaddr;
  logic              r_overrun;

  assign w_strobe  = i_take_action_a | i_take_action_b | i_take_no_action_a;
  assign w_blocked = r_pend | i_busy;
  assign w_accept  = w_strobe & ~w_blocked;
  assign w_queue   = w_accept & (i_take_action_b | i_take_no_action_a |
                                 (i_take_action_a & i_jdo[JDO_RDFLAG]));

  assign w_unused_jdo = ^{i_jdo[JDO_W-1:JDO_RDFLAG+1], i_jdo[JDO_DATA_LO-1:0]};

  always_comb begin
    w_cmd_new       = '0;
    w_cmd_new.wr    = i_take_action_b;
    w_cmd_new.incr  = i_take_action_b | i_take_no_action_a;
    w_cmd_new.wdata = i_jdo[JDO_DATA_HI:JDO_DATA_LO];
  end

  // Grant only happens while r_pend is set, so it never coincides with an accepted strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_cmd     <= '0;
      r_jaddr   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_grant) begin
        r_pend <= 1'b0;
        if (r_cmd.incr) begin
          r_jaddr <= r_jaddr + 1'b1;
        end
      end
      if (w_accept && i_take_action_a) begin
        r_jaddr <= RAM_AW'(i_jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
      end
      if (w_queue) begin
        r_pend <= 1'b1;
        r_cmd  <= w_cmd_new;
      end
      if (w_strobe && w_blocked) begin
        r_overrun <= 1'b1;
      end else if (w_accept && i_take_action_a) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_pend      = r_pend;
  assign o_cmd_wr    = r_cmd.wr;
  assign o_cmd_wdata = r_cmd.wdata;
  assign o_jaddr     = r_jaddr;
  assign o_queued    = w_queue;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/ethernet_sys_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Round-robin arbiter between JTAG debug commands and the Avalon debug-memory slave
// for the single-port OCI RAM; owns the RAM request and read-return registers.
module ethernet_sys_nios2_gen2_0_cpu_ocimem_arbiter
  import nios2_oci_pkg::*;
#(
  parameter int unsigned RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [RAM_AW-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [BE_W-1:0]   av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [BE_W-1:0]   ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  oci_state_e        r_state;
  oci_state_e        w_state_next;
  grant_e            r_last_grant;

  logic              w_av_req;
  logic              w_av_grant;
  logic              w_jt_grant;
  logic              w_jt_busy;
  logic              w_jt_pend;
  logic              w_jt_wr;
  logic              w_jt_queued;
  logic [DATA_W-1:0] w_jt_wdata;
  logic [RAM_AW-1:0] w_jaddr;
  logic              w_ram_wr_next;
  logic [BE_W-1:0]   w_ram_be_next;

  logic              r_ram_wr;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [BE_W-1:0]   r_ram_be;
  logic [DATA_W-1:0] r_av_rdata;
  logic [DATA_W-1:0] r_mon_dreg;
  logic              r_monitor_ready;

  ethernet_sys_nios2_gen2_0_cpu_ocimem_jtag_cmd #(
    .RAM_AW (RAM_AW)
  ) u_jtag_cmd (
    .clk                (clk),
    .reset              (reset),
    .i_jdo              (jdo),
    .i_take_action_a    (take_action_ocimem_a),
    .i_take_action_b    (take_action_ocimem_b),
    .i_take_no_action_a (take_no_action_ocimem_a),
    .i_busy             (w_jt_busy),
    .i_grant            (w_jt_grant),
    .o_pend             (w_jt_pend),
    .o_cmd_wr           (w_jt_wr),
    .o_cmd_wdata        (w_jt_wdata),
    .o_jaddr            (w_jaddr),
    .o_queued           (w_jt_queued),
    .o_overrun          (monitor_error)
  );

  assign w_av_req  = av_read | av_write;
  assign w_jt_busy = is_jt_state(r_state);

  always_comb begin
    w_state_next = r_state;
    w_av_grant   = 1'b0;
    w_jt_grant   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // On contention the side that did not win last time goes first.
        if (w_av_req && (!w_jt_pend || (r_last_grant == GrantJt))) begin
          w_av_grant = 1'b1;
        end else if (w_jt_pend) begin
          w_jt_grant = 1'b1;
        end
        if (w_av_grant) begin
          w_state_next = av_write ? StAvWr : StAvRd;
        end else if (w_jt_grant) begin
          w_state_next = w_jt_wr ? StJtWr : StJtRd;
        end
      end
      StAvRd:  w_state_next = StAvRdw;
      StJtRd:  w_state_next = StJtRdw;
      StAvWr, StJtWr, StAvRdw, StJtRdw: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_ram_wr_next = (w_state_next == StAvWr) || (w_state_next == StJtWr);
    w_ram_be_next = '0;
    if (w_av_grant && av_write) begin
      w_ram_be_next = av_byteenable;
    end else if (w_jt_grant && w_jt_wr) begin
      w_ram_be_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_last_grant <= GrantJt;
    end else begin
      r_state <= w_state_next;
      if (w_av_grant) begin
        r_last_grant <= GrantAv;
      end else if (w_jt_grant) begin
        r_last_grant <= GrantJt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_wr    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_be    <= '0;
    end else begin
      r_ram_wr <= w_ram_wr_next;
      r_ram_be <= w_ram_be_next;
      if (w_av_grant) begin
        r_ram_addr <= av_address;
        if (av_write) begin
          r_ram_wdata <= av_writedata;
        end
      end else if (w_jt_grant) begin
        r_ram_addr <= w_jaddr;
        if (w_jt_wr) begin
          r_ram_wdata <= w_jt_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_av_rdata      <= '0;
      r_mon_dreg      <= '0;
      r_monitor_ready <= 1'b1;
    end else begin
      if (r_state == StAvRdw) begin
        r_av_rdata <= ram_rdata;
      end
      if (r_state == StJtRdw) begin
        r_mon_dreg <= ram_rdata;
      end
      if ((r_state == StJtRdw) || (r_state == StJtWr)) begin
        r_monitor_ready <= 1'b1;
      end else if (w_jt_queued) begin
        r_monitor_ready <= 1'b0;
      end
    end
  end

  // RAM data arrives one cycle after the address, so the read-return cycle passes it through.
  assign av_readdata    = (r_state == StAvRdw) ? ram_rdata : r_av_rdata;
  assign av_waitrequest = !((r_state == StAvWr) || (r_state == StAvRdw));
  assign ram_wr         = r_ram_wr;
  assign ram_addr       = r_ram_addr;
  assign ram_wdata      = r_ram_wdata;
  assign ram_be         = r_ram_be;
  assign MonDReg        = r_mon_dreg;
  assign monitor_ready  = r_monitor_ready;

endmodule

// File: tb/tb_ethernet_sys_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Scoreboard bench for the OCI memory arbiter with a behavioural 256x32 synchronous RAM.
module tb_ethernet_sys_nios2_gen2_0_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata = 32'h0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  ethernet_sys_nios2_gen2_0_cpu_ocimem_arbiter #(
    .RAM_AW (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  function automatic logic [31:0] seed(input logic [7:0] a);
    return {a, ~a, 8'h5A, a};
  endfunction

  // Behavioural RAM, preloaded so every read value identifies its address.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = seed(i[7:0]);

  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[ram_addr];
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) if (ram_be[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      mem[ram_addr] <= w;
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef enum int {EvAvRd, EvAvWr, EvJtRd, EvJtWr} ev_kind_e;
  typedef struct {ev_kind_e kind; logic [31:0] data;} ev_t;
  typedef struct {logic [7:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;

  ev_t q_ev[$];
  wr_t q_wr[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    q_ev.push_back(e);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.be   = be;
    q_wr.push_back(w);
  endtask

  task automatic pop_ev(input ev_kind_e obs, input logic [31:0] d);
    ev_t e;
    if (q_ev.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, expected none", obs);
    end else begin
      e = q_ev.pop_front();
      check("event_order", int'(obs), int'((e.kind == EvJtWr) ? EvJtRd : e.kind));
      if (e.kind == EvAvRd || e.kind == EvJtRd) check("read_data", d, e.data);
    end
  endtask

  task automatic pop_wr();
    wr_t w;
    if (q_wr.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ram_write: got addr %h, expected none", ram_addr);
    end else begin
      w = q_wr.pop_front();
      check("ram_write_addr", {24'h0, ram_addr}, {24'h0, w.addr});
      check("ram_write_data", ram_wdata, w.data);
      check("ram_write_be", {28'h0, ram_be}, {28'h0, w.be});
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a completion.
  logic prev_ready = 1'b1;
  logic prev_reset = 1'b1;
  always @(negedge clk) begin
    if (!reset && !prev_reset) begin
      if (monitor_ready && !prev_ready) pop_ev(EvJtRd, MonDReg);
      if (!av_waitrequest && av_write) pop_ev(EvAvWr, 32'h0);
      else if (!av_waitrequest && av_read) pop_ev(EvAvRd, av_readdata);
      if (ram_wr) pop_wr();
    end
    prev_ready <= monitor_ready;
    prev_reset <= reset;
  end

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] v;
    v = '0;
    v[17:10] = a;
    v[35] = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 = take_action_a, 1 = take_action_b, 2 = take_no_action_a
  task automatic strobe(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!monitor_ready && n < bound) begin
      n++;
      @(negedge clk);
    end
    if (n >= bound) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got monitor_ready 0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ready_timing(input string name, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check(name, monitor_ready, (k == n));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic av_rd(input logic [7:0] a, output int lat);
    av_address = a;
    av_read    = 1'b1;
    lat = 0;
    @(negedge clk);
    while (av_waitrequest && lat < 30) begin
      lat++;
      @(negedge clk);
    end
    if (lat >= 30) $display("FAIL av_read_timeout: got waitrequest 1, expected 0");
    @(posedge clk);
    #1;
    av_read = 1'b0;
  endtask

  task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic both, output int lat);
    av_address    = a;
    av_writedata  = d;
    av_byteenable = be;
    av_write      = 1'b1;
    av_read       = both;
    lat = 0;
    @(negedge clk);
    while (av_waitrequest && lat < 30) begin
      lat++;
      @(negedge clk);
    end
    if (lat >= 30) $display("FAIL av_write_timeout: got waitrequest 1, expected 0");
    @(posedge clk);
    #1;
    av_write = 1'b0;
    av_read  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lat2;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    av_address = '0;
    av_read = 1'b0;
    av_write = 1'b0;
    av_writedata = '0;
    av_byteenable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", av_waitrequest, 1);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_ram_be", ram_be, 0);
    check("rst_av_readdata", av_readdata, 0);
    check("rst_mondreg", MonDReg, 0);
    check("rst_monitor_ready", monitor_ready, 1);
    check("rst_monitor_error", monitor_error, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Avalon read and JTAG read strobe in the same cycle: Avalon first, then JTAG at jaddr 0.
    push_ev(EvAvRd, seed(8'h20));
    push_ev(EvJtRd, seed(8'h00));
    fork
      av_rd(8'h20, lat);
      strobe(2, '0);
    join
    check("contention_av_latency", lat, 2);
    wait_ready(20);

    // True tie with last grant = Avalon: JTAG wins over the back-to-back Avalon read.
    push_ev(EvAvRd, seed(8'h21));
    push_ev(EvJtRd, seed(8'h01));
    push_ev(EvAvRd, seed(8'h22));
    fork
      begin
        av_rd(8'h21, lat);
        av_rd(8'h22, lat2);
      end
      begin
        cyc(1);
        strobe(2, '0);
      end
    join
    check("tie_first_av_latency", lat, 2);
    check("tie_second_av_latency", lat2, 5);

    // JTAG write then read-back at 0x10.
    strobe(0, jdo_a(8'h10, 1'b0));
    @(negedge clk);
    check("load_keeps_ready", monitor_ready, 1);
    @(posedge clk);
    #1;
    push_wr(8'h10, 32'hDEADBEEF, 4'hF);
    push_ev(EvJtWr, 32'h0);
    strobe(1, jdo_b(32'hDEADBEEF));
    ready_timing("jt_write_ready_cycle", 3);
    push_ev(EvJtRd, seed(8'h11));
    strobe(2, '0);
    ready_timing("jt_read_ready_cycle", 4);
    push_ev(EvJtRd, 32'hDEADBEEF);
    strobe(0, jdo_a(8'h10, 1'b1));
    ready_timing("jt_load_read_ready_cycle", 4);

    // jaddr wrap 0xFF -> 0x00.
    strobe(0, jdo_a(8'hFF, 1'b0));
    push_ev(EvJtRd, seed(8'hFF));
    strobe(2, '0);
    wait_ready(20);
    push_ev(EvJtRd, seed(8'h00));
    strobe(2, '0);
    wait_ready(20);

    // Overrun: back-to-back strobes, second dropped; jaddr advances only once.
    check("error_before_overrun", monitor_error, 0);
    push_ev(EvJtRd, seed(8'h01));
    strobe(2, '0);
    strobe(2, '0);
    wait_ready(20);
    check("error_after_overrun", monitor_error, 1);
    push_ev(EvJtRd, seed(8'h02));
    strobe(2, '0);
    wait_ready(20);
    check("error_sticky", monitor_error, 1);
    push_ev(EvJtRd, seed(8'h30));
    strobe(0, jdo_a(8'h30, 1'b1));
    @(negedge clk);
    check("error_cleared_by_a", monitor_error, 0);
    wait_ready(20);

    // Avalon byte write: byte 1 of 0x05 replaced (05FA5A05 -> 05FAAB05).
    push_wr(8'h05, 32'h0000AB00, 4'b0010);
    push_ev(EvAvWr, 32'h0);
    av_address = 8'h05;
    av_writedata = 32'h0000AB00;
    av_byteenable = 4'b0010;
    av_write = 1'b1;
    @(negedge clk);
    check("bw_wait_c0", av_waitrequest, 1);
    check("bw_be_c0", ram_be, 4'b0000);
    @(negedge clk);
    check("bw_wait_c1", av_waitrequest, 0);
    check("bw_be_c1", ram_be, 4'b0010);
    @(posedge clk);
    #1 av_write = 1'b0;
    @(negedge clk);
    check("bw_wait_c2", av_waitrequest, 1);
    check("bw_be_c2", ram_be, 4'b0000);
    @(posedge clk);
    #1;
    push_ev(EvAvRd, 32'h05FAAB05);
    av_rd(8'h05, lat);
    check("bw_readback_latency", lat, 2);

    // Read and write together: write wins.
    push_wr(8'h06, 32'h12345678, 4'hF);
    push_ev(EvAvWr, 32'h0);
    av_wr(8'h06, 32'h12345678, 4'hF, 1'b1, lat);
    check("both_write_latency", lat, 1);
    push_ev(EvAvRd, 32'h12345678);
    av_rd(8'h06, lat);

    // Reset while a JTAG read is in JT_RD; no completion expected.
    strobe(2, '0);
    cyc(1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_monitor_ready", monitor_ready, 1);
    check("midrst_mondreg", MonDReg, 0);
    check("midrst_ram_wr", ram_wr, 0);
    check("midrst_waitrequest", av_waitrequest, 1);
    cyc(4);
    @(negedge clk);
    check("midrst_no_update", MonDReg, 0);
    check("midrst_ready_held", monitor_ready, 1);
    @(posedge clk);
    #1;

    // After reset: Avalon read from IDLE and JTAG read at jaddr 0.
    push_ev(EvAvRd, seed(8'h20));
    av_rd(8'h20, lat);
    check("post_rst_av_latency", lat, 2);
    push_ev(EvJtRd, seed(8'h00));
    strobe(2, '0);
    ready_timing("post_rst_jt_read", 4);

    cyc(5);
    check("ev_queue_empty", q_ev.size(), 0);
    check("wr_queue_empty", q_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
